// File: rtl/bor_pkg.sv
// Shared types and default constants for the OR-gate input conditioner.
// Also holds the helper that maps a debounce state to its clean output level.
package bor_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } bor_state_e;

  localparam int BOR_SYNC_STAGES     = 2;
  localparam int BOR_DEBOUNCE_CYCLES = 50000;
  localparam int BOR_CNT_W           = 16;

  // A channel reads high while settled high or while qualifying a drop.
  function automatic logic bor_level(input bor_state_e st);
    logic lvl;
    case (st)
      STABLE_HIGH: lvl = 1'b1;
      WAIT_LOW:    lvl = 1'b1;
      default:     lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/bor_debounce_chan.sv
// One conditioning channel: synchroniser chain, stability counter and FSM.
// All outputs are registered next-state decodes, so raw never reaches them combinationally.
module bor_debounce_chan
  import bor_pkg::*;
#(
  parameter int SYNC_STAGES     = BOR_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = BOR_DEBOUNCE_CYCLES,
  parameter int CNT_W           = BOR_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  bor_state_e             state_r;
  bor_state_e             state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   clean_r;
  logic                   rise_r;
  logic                   fall_r;
  logic                   clean_nxt_s;
  logic                   rise_nxt_s;
  logic                   fall_nxt_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain bringing raw into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= STABLE_LOW;
      cnt_r   <= CNT_ZERO;
      clean_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      clean_r <= clean_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
    end
  end

  // Next-state and counter logic; the counter stops at CNT_LAST so it never wraps.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      STABLE_LOW: begin
        if (sync_s) begin
          state_nxt_s = WAIT_HIGH;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = STABLE_LOW;
        end
      end
      WAIT_HIGH: begin
        if (!sync_s) begin
          state_nxt_s = STABLE_LOW;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = STABLE_HIGH;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!sync_s) begin
          state_nxt_s = WAIT_LOW;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = STABLE_HIGH;
        end
      end
      WAIT_LOW: begin
        if (sync_s) begin
          state_nxt_s = STABLE_HIGH;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = STABLE_LOW;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = STABLE_LOW;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode: pulses come only from the qualifying WAIT->STABLE transitions.
  always_comb begin
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    clean_nxt_s = bor_level(state_nxt_s);
    case (state_r)
      WAIT_HIGH: begin
        if (state_nxt_s == STABLE_HIGH) begin
          rise_nxt_s = 1'b1;
        end else begin
          rise_nxt_s = 1'b0;
        end
      end
      WAIT_LOW: begin
        if (state_nxt_s == STABLE_LOW) begin
          fall_nxt_s = 1'b1;
        end else begin
          fall_nxt_s = 1'b0;
        end
      end
      default: begin
        rise_nxt_s = 1'b0;
        fall_nxt_s = 1'b0;
      end
    endcase
  end

  assign clean = clean_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/bor_input_conditioner.sv
// Two independent debounce channels producing the clean a/b levels for the OR gate,
// plus per-channel rise/fall event pulses.
module bor_input_conditioner
  import bor_pkg::*;
#(
  parameter int SYNC_STAGES     = BOR_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = BOR_DEBOUNCE_CYCLES,
  parameter int CNT_W           = BOR_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_clean,
  output logic b_clean,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  bor_debounce_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (a_raw),
    .clean(a_clean),
    .rise (a_rise),
    .fall (a_fall)
  );

  bor_debounce_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (b_raw),
    .clean(b_clean),
    .rise (b_rise),
    .fall (b_fall)
  );

endmodule

// File: tb/tb_bor_input_conditioner.sv
// Randomised and directed bench for bor_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// The reference treats each channel as a delay line followed by a run-length rule.
module tb_bor_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a_clean, b_clean, a_rise, a_fall, b_rise, b_fall;
  logic [5:0] obs_s;

  int errors = 0;
  int checks = 0;

  // Reference: raw seen SYNC edges late; clean flips after DEB+1 consecutive disagreeing samples.
  logic dly [2][SYNC];
  int   run [2];
  logic m_clean [2];
  logic m_rise [2];
  logic m_fall [2];

  bor_input_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw),
    .a_clean(a_clean), .b_clean(b_clean), .a_rise(a_rise), .a_fall(a_fall),
    .b_rise(b_rise), .b_fall(b_fall)
  );

  always #5 clk = ~clk;

  assign obs_s = {a_clean, a_rise, a_fall, b_clean, b_rise, b_fall};

  function automatic logic [5:0] model_vec();
    return {m_clean[0], m_rise[0], m_fall[0], m_clean[1], m_rise[1], m_fall[1]};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < SYNC; i++) dly[c][i] = 1'b0;
      run[c] = 0; m_clean[c] = 1'b0; m_rise[c] = 1'b0; m_fall[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic a, input logic b);
    logic rawv [2];
    logic s;
    rawv[0] = a; rawv[1] = b;
    for (int c = 0; c < 2; c++) begin
      s = dly[c][SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) dly[c][i] = dly[c][i-1];
      dly[c][0] = rawv[c];
      m_rise[c] = 1'b0; m_fall[c] = 1'b0;
      if (s != m_clean[c]) run[c]++; else run[c] = 0;
      if (run[c] == DEB + 1) begin
        m_clean[c] = s;
        m_rise[c]  = s;
        m_fall[c]  = ~s;
        run[c]     = 0;
      end
    end
  endtask

  // Drive inputs, advance one edge, update the reference; sampling happens 1 time unit later.
  task automatic step(input logic a, input logic b);
    a_raw = a; b_raw = b;
    @(posedge clk);
    #1;
    model_edge(a, b);
  endtask

  task automatic test_reset();
    int first_rise, rise_cnt;
    rst_n = 1'b0; a_raw = 1'b1; b_raw = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_s !== 6'b000000) begin
      errors++; $display("FAIL reset_hold got=%b want=000000", obs_s);
    end
    rst_n = 1'b1;
    first_rise = 0; rise_cnt = 0;
    for (int e = 1; e <= 10; e++) begin
      step(1'b1, 1'b1);
      checks++;
      if (obs_s !== model_vec()) begin
        errors++; $display("FAIL reset_release edge=%0d got=%b want=%b", e, obs_s, model_vec());
      end
      if (a_clean && first_rise == 0) first_rise = e;
      if (a_rise) rise_cnt++;
    end
    checks++;
    if (first_rise !== 7 || rise_cnt !== 1) begin
      errors++; $display("FAIL reset_first_rise got edge=%0d pulses=%0d want edge=7 pulses=1", first_rise, rise_cnt);
    end
  endtask

  task automatic test_clean_step();
    int first_rise, rise_cnt, b_moves;
    for (int e = 0; e < 12; e++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs_s !== model_vec()) begin
        errors++; $display("FAIL step_settle got=%b want=%b", obs_s, model_vec());
      end
    end
    first_rise = 0; rise_cnt = 0; b_moves = 0;
    for (int e = 1; e <= 12; e++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs_s !== model_vec()) begin
        errors++; $display("FAIL step_a edge=%0d got=%b want=%b", e, obs_s, model_vec());
      end
      if (a_clean && first_rise == 0) first_rise = e;
      if (a_rise) rise_cnt++;
      if (b_clean || b_rise || b_fall) b_moves++;
    end
    checks++;
    if (first_rise !== 7 || rise_cnt !== 1 || b_moves !== 0) begin
      errors++; $display("FAIL step_latency got edge=%0d pulses=%0d b_moves=%0d want 7/1/0", first_rise, rise_cnt, b_moves);
    end
  endtask

  task automatic test_glitch();
    int rise_cnt, seen_hi;
    for (int e = 0; e < 12; e++) step(1'b0, 1'b0);
    rise_cnt = 0; seen_hi = 0;
    for (int e = 0; e < 14; e++) begin
      step((e < 4) ? 1'b1 : 1'b0, 1'b0);
      checks++;
      if (obs_s !== model_vec()) begin
        errors++; $display("FAIL glitch4 cyc=%0d got=%b want=%b", e, obs_s, model_vec());
      end
      if (a_rise) rise_cnt++;
      if (a_clean) seen_hi++;
    end
    checks++;
    if (rise_cnt !== 0 || seen_hi !== 0) begin
      errors++; $display("FAIL glitch4_reject got pulses=%0d hi=%0d want 0/0", rise_cnt, seen_hi);
    end
    rise_cnt = 0;
    for (int e = 0; e < 16; e++) begin
      step((e < 5) ? 1'b1 : 1'b0, 1'b0);
      checks++;
      if (obs_s !== model_vec()) begin
        errors++; $display("FAIL glitch5 cyc=%0d got=%b want=%b", e, obs_s, model_vec());
      end
      if (a_rise) rise_cnt++;
    end
    checks++;
    if (rise_cnt !== 1) begin
      errors++; $display("FAIL glitch5_accept got pulses=%0d want 1", rise_cnt);
    end
  endtask

  task automatic test_bounce();
    int first_rise, rise_cnt;
    for (int e = 0; e < 12; e++) step(1'b0, 1'b0);
    rise_cnt = 0;
    for (int e = 0; e < 10; e++) begin
      step((e % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      checks++;
      if (obs_s !== model_vec()) begin
        errors++; $display("FAIL bounce_toggle cyc=%0d got=%b want=%b", e, obs_s, model_vec());
      end
      if (a_rise) rise_cnt++;
    end
    first_rise = 0;
    for (int e = 1; e <= 10; e++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs_s !== model_vec()) begin
        errors++; $display("FAIL bounce_settle edge=%0d got=%b want=%b", e, obs_s, model_vec());
      end
      if (a_clean && first_rise == 0) first_rise = e;
      if (a_rise) rise_cnt++;
    end
    checks++;
    if (first_rise !== 7 || rise_cnt !== 1) begin
      errors++; $display("FAIL bounce_latency got edge=%0d pulses=%0d want 7/1", first_rise, rise_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int first_rise;
    for (int e = 0; e < 12; e++) step(1'b0, 1'b0);
    for (int e = 0; e < 5; e++) step(1'b1, 1'b0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_s !== 6'b000000) begin
      errors++; $display("FAIL midreset_async got=%b want=000000", obs_s);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    first_rise = 0;
    for (int e = 1; e <= 9; e++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs_s !== model_vec()) begin
        errors++; $display("FAIL midreset_requal edge=%0d got=%b want=%b", e, obs_s, model_vec());
      end
      if (a_clean && first_rise == 0) first_rise = e;
    end
    checks++;
    if (first_rise !== 7) begin
      errors++; $display("FAIL midreset_latency got edge=%0d want 7", first_rise);
    end
    // Asynchronous reset must also drop an already-high clean level before any edge.
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (a_clean !== 1'b0) begin
      errors++; $display("FAIL reset_clears_high got=%b want=0", a_clean);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_simultaneous();
    int ra, rb, fa, fb;
    for (int e = 0; e < 12; e++) step(1'b0, 1'b0);
    ra = 0; rb = 0; fa = 0; fb = 0;
    for (int e = 1; e <= 20; e++) begin
      step((e <= 10) ? 1'b1 : 1'b0, (e <= 10) ? 1'b1 : 1'b0);
      checks++;
      if (obs_s !== model_vec() || (a_clean | b_clean) !== (m_clean[0] | m_clean[1])) begin
        errors++; $display("FAIL simul edge=%0d got=%b want=%b", e, obs_s, model_vec());
      end
      if (a_rise) ra = e;
      if (b_rise) rb = e;
      if (a_fall) fa = e;
      if (b_fall) fb = e;
    end
    checks++;
    if (ra !== 7 || rb !== 7 || fa !== 17 || fb !== 17) begin
      errors++; $display("FAIL simul_pulses got ra=%0d rb=%0d fa=%0d fb=%0d want 7 7 17 17", ra, rb, fa, fb);
    end
  endtask

  task automatic test_random();
    logic va, vb;
    int   ha, hb;
    va = 1'b0; vb = 1'b0; ha = 0; hb = 0;
    for (int e = 0; e < 600; e++) begin
      if (ha == 0) begin va = ~va; ha = $urandom_range(1, 8); end
      if (hb == 0) begin vb = ~vb; hb = $urandom_range(1, 8); end
      ha--; hb--;
      step(va, vb);
      checks++;
      if (obs_s !== model_vec() || (a_rise && a_fall) || (b_rise && b_fall)) begin
        errors++; $display("FAIL random cyc=%0d got=%b want=%b", e, obs_s, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_mid_reset();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bor_input_conditioner.md
Name: bor_input_conditioner

Overview:
- Dual-channel synchroniser/debouncer sitting directly upstream of the two-input OR gate.
- Converts asynchronous, bouncy raw inputs (switches, buttons) into clean, glitch-free levels `a_clean`/`b_clean`.
- These clean levels drive the OR gate's `a`/`b` inputs.
- Also emits single-cycle rise/fall event pulses per channel for downstream counters/logging.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchroniser chain (legal range >=2).
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronised cycles required before a level change is accepted (legal range >=1).
- CNT_W, 16, stability counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock; all state is rising-edge triggered.
- rst_n  input  1  asynchronous assert, active-low reset.
- a_raw  input  1  raw asynchronous channel A.
- b_raw  input  1  raw asynchronous channel B.
- a_clean  output  1  debounced level A; feeds the OR gate input a.
- b_clean  output  1  debounced level B; feeds the OR gate input b.
- a_rise  output  1  one-cycle pulse when a_clean goes 0->1.
- a_fall  output  1  one-cycle pulse when a_clean goes 1->0.
- b_rise  output  1  one-cycle pulse when b_clean goes 0->1.
- b_fall  output  1  one-cycle pulse when b_clean goes 1->0.

Behaviour:
- Reset (rst_n=0, asynchronous, any time, including mid-count):
  - Sync chains, counters, and all outputs clear to 0.
  - Each channel FSM returns to STABLE_LOW.
- On release, the first active edge behaves as the first post-reset cycle; no pulses are emitted due to reset.
- Channels are fully independent and identical; `s` denotes a channel's synchronised input (last sync stage).
- FSM per channel: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
  - STABLE_LOW: s=1 -> WAIT_HIGH, cnt<=0; else stay.
  - WAIT_HIGH:
    - s=0 -> STABLE_LOW (glitch rejected, no pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, clean<=1, rise<=1 for exactly one cycle.
    - Else cnt<=cnt+1.
  - STABLE_HIGH / WAIT_LOW: mirror image, with s=0 qualifying and a fall pulse.
- cnt saturates by construction; it never wraps, since the FSM exits at DEBOUNCE_CYCLES-1.
- Outputs are registered (no combinational path from raw to any output).
- rise/fall are derived from the state transition, never from clean edge detection on a delayed copy.
- Latency: raw change stable before edge 1 -> clean changes after edge SYNC_STAGES+1+DEBOUNCE_CYCLES; the rise/fall pulse is asserted in that same cycle.
- Rejection: a raw pulse of <=DEBOUNCE_CYCLES cycles (after sync) never changes clean; >=DEBOUNCE_CYCLES+1 cycles always does.
- rise and fall on one channel are never asserted in the same cycle.
- Consecutive events on a channel are separated by >=DEBOUNCE_CYCLES+1 cycles.
- Simultaneous qualifying changes on A and B produce simultaneous pulses on both channels.

Decomposition:
- Shared package `bor_pkg` holds:
  - The 2-bit state enum: STABLE_LOW=0, WAIT_HIGH=1, STABLE_HIGH=2, WAIT_LOW=3.
  - The default parameter constants.
- One sub-module, `bor_debounce_chan`, contains one sync chain, counter and FSM, with ports clk, rst_n, raw, clean, rise, fall.
- The top instantiates `bor_debounce_chan` twice.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset: hold rst_n=0 with a_raw=b_raw=1 -> all outputs 0; deassert, and a_clean rises after edge 7 with a single a_rise pulse.
- Clean step: a_raw 0->1 held -> a_clean=1 exactly after 7th edge; a_rise high exactly 1 cycle; b outputs unchanged.
- Glitch: a_raw high for 4 cycles, then low -> a_clean stays 0, no a_rise; a 5-cycle pulse -> a_clean=1 and a_rise fires.
- Bounce: a_raw toggles every cycle for 10 cycles, then settles at 1 -> a_clean rises exactly 7 edges after final settle, with one pulse only.
- Mid-count reset: a_raw=1, assert rst_n low during WAIT_HIGH (cnt=2) -> outputs stay 0 immediately; after release, a full 7-edge qualification is required again.
- Simultaneous: a_raw and b_raw 0->1 on the same cycle, later both 1->0 -> a_rise/b_rise coincide, then a_fall/b_fall coincide; a_clean|b_clean matches the expected OR.
